// File: rtl/i2c_slave_phy.sv
// Bit-level I2C slave front end: synchronised/filtered SCL/SDA, START/STOP detection,
// 7-bit address match, write-byte capture and read-byte shifting with open-drain SDA drive.
module i2c_slave_phy #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [6:0] address,
  input  logic [7:0] datasend,
  output logic [7:0] datareceive,
  output logic       received,
  output logic       sended,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t state, state_n;

  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q  [2];
  logic [2:0]             flt_cnt [2];
  logic [1:0]             flt, flt_q;

  assign raw = {sda_in, scl_in};

  // Index 0 = SCL, 1 = SDA; filtered level moves only after FILTER_CYCLES equal samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        sync_q[i]  <= '1;
        flt_cnt[i] <= '0;
      end
      flt   <= '1;
      flt_q <= '1;
    end else begin
      flt_q <= flt;
      for (int unsigned i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        if (sync_q[i][SYNC_STAGES-1] == flt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == 3'(FILTER_CYCLES - 1)) begin
          flt[i]     <= sync_q[i][SYNC_STAGES-1];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 3'd1;
        end
      end
    end
  end

  logic sda_f, scl_rise, scl_fall, start_cond, stop_cond;
  assign sda_f      = flt[1];
  assign scl_rise   = flt[0] & ~flt_q[0];
  assign scl_fall   = ~flt[0] & flt_q[0];
  assign start_cond = ~flt[1] & flt_q[1] & flt[0] & flt_q[0];
  assign stop_cond  = flt[1] & ~flt_q[1] & flt[0] & flt_q[0];

  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n, tx, tx_n, datareceive_n;
  logic       rw, rw_n, match, match_n, ack, ack_n;
  logic       sda_oe_n, received_n, sended_n, busy_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      tx          <= '0;
      rw          <= 1'b0;
      match       <= 1'b0;
      ack         <= 1'b1;
      sda_oe      <= 1'b0;
      datareceive <= '0;
      received    <= 1'b0;
      sended      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      tx          <= tx_n;
      rw          <= rw_n;
      match       <= match_n;
      ack         <= ack_n;
      sda_oe      <= sda_oe_n;
      datareceive <= datareceive_n;
      received    <= received_n;
      sended      <= sended_n;
      busy        <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    if (start_cond) begin
      state_n = ADDR;
    end else if (stop_cond) begin
      state_n = IDLE;
    end else if (scl_fall) begin
      case (state)
        ADDR:     if (bit_cnt == 4'd8) state_n = match ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: state_n = rw ? RD_DATA : WR_DATA;
        WR_DATA:  if (bit_cnt == 4'd8) state_n = WR_ACK;
        WR_ACK:   state_n = WR_DATA;
        RD_DATA:  if (bit_cnt == 4'd8) state_n = RD_ACK;
        RD_ACK:   state_n = ack ? WAIT_STOP : RD_DATA;
        default:  state_n = state;
      endcase
    end
  end

  // Strobe clear on scl_rise is applied first so a same-cycle set overrides it
  always_comb begin
    bit_cnt_n     = bit_cnt;
    shift_n       = shift;
    tx_n          = tx;
    rw_n          = rw;
    match_n       = match;
    ack_n         = ack;
    sda_oe_n      = sda_oe;
    datareceive_n = datareceive;
    received_n    = received;
    sended_n      = sended;
    busy_n        = busy;
    if (scl_rise) begin
      received_n = 1'b0;
      sended_n   = 1'b0;
    end
    if (start_cond) begin
      bit_cnt_n  = '0;
      sda_oe_n   = 1'b0;
      received_n = 1'b0;
      sended_n   = 1'b0;
    end else if (stop_cond) begin
      sda_oe_n   = 1'b0;
      received_n = 1'b0;
      sended_n   = 1'b0;
      busy_n     = 1'b0;
    end else begin
      case (state)
        ADDR, WR_DATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shift_n   = {shift[6:0], sda_f};
            bit_cnt_n = bit_cnt + 4'd1;
            if (state == ADDR && bit_cnt == 4'd7) begin
              match_n = (shift[6:0] == address);
              rw_n    = sda_f;
            end
          end
          if (scl_fall && bit_cnt == 4'd8) begin
            if (state == ADDR) begin
              sda_oe_n = match;
              busy_n   = match;
            end else begin
              datareceive_n = shift;
              received_n    = 1'b1;
              sda_oe_n      = 1'b1;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          bit_cnt_n = '0;
          if (rw) begin
            tx_n     = datasend;
            sda_oe_n = ~datasend[7];
          end else begin
            sda_oe_n = 1'b0;
          end
        end
        WR_ACK: if (scl_fall) begin
          sda_oe_n  = 1'b0;
          bit_cnt_n = '0;
        end
        RD_DATA: begin
          if (scl_rise && bit_cnt < 4'd8) bit_cnt_n = bit_cnt + 4'd1;
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n = 1'b0;
            end else begin
              tx_n     = {tx[6:0], 1'b0};
              sda_oe_n = ~tx[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ack_n    = sda_f;
            sended_n = 1'b1;
          end
          if (scl_fall) begin
            if (!ack) begin
              tx_n      = datasend;
              sda_oe_n  = ~datasend[7];
              bit_cnt_n = '0;
            end else begin
              sda_oe_n = 1'b0;
            end
          end
        end
        WAIT_STOP: sda_oe_n = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_phy.sv
// Directed bench for i2c_slave_phy: bus-master tasks drive an open-drain SDA line,
// and all results are compared against hand-computed constants.
module tb_i2c_slave_phy;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [6:0] address = 7'h3C;
  logic [7:0] datasend = 8'h00;
  logic [7:0] datareceive;
  logic       received, sended, busy;

  int checks = 0;
  int failures = 0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_phy #(.SYNC_STAGES(2), .FILTER_CYCLES(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .scl_in      (scl_m),
    .sda_in      (sda_line),
    .sda_oe      (sda_oe),
    .address     (address),
    .datasend    (datasend),
    .datareceive (datareceive),
    .received    (received),
    .sended      (sended),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic clock_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic glitch,
                           output logic ack_oe, output logic rcv_before);
    for (int i = 7; i >= 0; i--) begin
      if (glitch && i == 3) begin
        scl_m = 1'b1; wait_clk(2);
        scl_m = 1'b0; wait_clk(Q);
      end
      clock_bit(b[i]);
    end
    sda_m = 1'b1; wait_clk(Q);
    rcv_before = received;
    scl_m = 1'b1; wait_clk(Q);
    ack_oe = sda_oe;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_byte(input logic ack_bit, input logic [7:0] next_ds,
                           output logic [7:0] data, output logic snd);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      data[i] = sda_line;
      wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
    end
    sda_m = ack_bit; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    snd = sended;
    datasend = next_ds;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  initial begin
    logic       a, r, s;
    logic [7:0] d;

    wait_clk(3);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_received", received, 0);
    check("reset_sended", sended, 0);
    check("reset_datareceive", datareceive, 8'h00);
    reset = 1'b1;
    wait_clk(4);

    // 1: matched write of 0xA5
    bus_start();
    send_byte(8'h78, 1'b0, a, r);
    check("t1_addr_ack", a, 1);
    check("t1_busy", busy, 1);
    send_byte(8'hA5, 1'b0, a, r);
    check("t1_data_ack", a, 1);
    check("t1_received_set", r, 1);
    check("t1_datareceive", datareceive, 8'hA5);
    check("t1_received_clr", received, 0);
    bus_stop();
    check("t1_busy_stop", busy, 0);

    // 2: address 0x3D does not match
    bus_start();
    send_byte(8'h7A, 1'b0, a, r);
    check("t2_addr_nack", a, 0);
    check("t2_busy", busy, 0);
    send_byte(8'hFF, 1'b0, a, r);
    check("t2_data_nack", a, 0);
    check("t2_received", r, 0);
    check("t2_datareceive", datareceive, 8'hA5);
    bus_stop();

    // 3: write 0x00, repeated START, read 0x55
    datasend = 8'h55;
    bus_start();
    send_byte(8'h78, 1'b0, a, r);
    check("t3_addr_ack", a, 1);
    send_byte(8'h00, 1'b0, a, r);
    check("t3_datareceive", datareceive, 8'h00);
    bus_start();
    send_byte(8'h79, 1'b0, a, r);
    check("t3_raddr_ack", a, 1);
    read_byte(1'b1, 8'h00, d, s);
    check("t3_read_byte", d, 8'h55);
    check("t3_sended", s, 1);
    bus_stop();
    check("t3_sended_stop", sended, 0);
    check("t3_sda_oe_stop", sda_oe, 0);

    // 6: sub-filter SCL glitch inside a write byte
    bus_start();
    send_byte(8'h78, 1'b0, a, r);
    send_byte(8'hC3, 1'b1, a, r);
    check("t6_ack", a, 1);
    check("t6_datareceive", datareceive, 8'hC3);
    bus_stop();

    // 4: two-byte read, NACK on the second
    datasend = 8'h12;
    bus_start();
    send_byte(8'h79, 1'b0, a, r);
    read_byte(1'b0, 8'h34, d, s);
    check("t4_byte0", d, 8'h12);
    check("t4_sended0", s, 1);
    read_byte(1'b1, 8'h00, d, s);
    check("t4_byte1", d, 8'h34);
    check("t4_sended1", s, 1);
    check("t4_sda_oe_nack", sda_oe, 0);
    check("t4_busy_wait", busy, 1);
    clock_bit(1'b1);
    check("t4_sda_oe_wait", sda_oe, 0);
    bus_stop();
    check("t4_busy_stop", busy, 0);

    // 5: asynchronous reset while driving a read 0-bit
    datasend = 8'h00;
    bus_start();
    send_byte(8'h79, 1'b0, a, r);
    check("t5_driving", sda_oe, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_async_sda_oe", sda_oe, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_datareceive", datareceive, 8'h00);
    wait_clk(2);
    reset = 1'b1;
    sda_m = 1'b1; scl_m = 1'b1;
    wait_clk(2*Q);
    bus_start();
    send_byte(8'h78, 1'b0, a, r);
    check("t5_restart_ack", a, 1);
    send_byte(8'h3C, 1'b0, a, r);
    check("t5_datareceive", datareceive, 8'h3C);
    bus_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
